// File: rtl/uart_blink_cmd.sv
// uart_blink_cmd
//   UART receiver plus two-byte command decoder that configures the LED
//   blink generator. The host sends an opcode byte followed by a data byte:
//     'M' (0x4D) : blink_mask <= data
//     'R' (0x52) : rate_sel   <= data[1:0]
//     'E' (0x45) : blink_en   <= data[0]
//   Unknown opcodes are ignored. If the data byte does not start within
//   TIMEOUT_BITS bit periods of the opcode, the opcode is dropped.
//
//   Optional feature: define UART_PARITY_EN to receive 8E1 frames (an even
//   parity bit between bit 7 and the stop bit). A parity mismatch is handled
//   like a bad stop bit. Without the macro the frame is 8N1.
//
// Parameters:
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         serial bit rate
//   TIMEOUT_BITS bit periods allowed between opcode and data start bit
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   blink_mask LEDs that toggle (1 = toggling), reset 8'h55
//   rate_sel   toggle period select (0 = 1 s .. 3 = 1/8 s), reset 2
//   blink_en   blink generator enable, reset 1
//   cfg_strobe one-cycle pulse when a configuration register is written
//   frame_err  one-cycle pulse on a rejected byte (bad stop or parity)

module uart_blink_cmd #(
   parameter int CLK_FREQ     = 25_000_000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] blink_mask,
   output logic [1:0] rate_sel,
   output logic       blink_en,
   output logic       cfg_strobe,
   output logic       frame_err
);

   localparam int BIT_CNT  = CLK_FREQ / BAUD;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CNT_W    = $clog2(BIT_CNT + 1);
   localparam int TMO_CNT  = TIMEOUT_BITS * BIT_CNT;
   localparam int TMO_W    = $clog2(TMO_CNT + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CNT - 1);

   localparam logic [7:0] OP_MASK = 8'h4D;
   localparam logic [7:0] OP_RATE = 8'h52;
   localparam logic [7:0] OP_EN   = 8'h45;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_t;

   typedef enum logic {
      DEC_WAIT_OP,
      DEC_WAIT_DATA
   } dec_state_t;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_MASK) || (b == OP_RATE) || (b == OP_EN);
   endfunction

   // ---- input synchronizer: rx_p0 -> rx_p1, rx_prev for edge detect ----
   logic rx_p0, rx_p1, rx_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0   <= 1'b1;
         rx_p1   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_p0   <= rx;
         rx_p1   <= rx_p0;
         rx_prev <= rx_p1;
      end
   end

   logic rx_fall;
   assign rx_fall = rx_prev & ~rx_p1;

   // ---- receiver FSM: samples mid-bit, emits rx_done / frame_err ----
   rx_state_t        rx_state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       rx_byte;
   logic             rx_done;
   logic             stop_ok;
`ifdef UART_PARITY_EN
   logic             par_err;
   assign stop_ok = rx_p1 & ~par_err;
`else
   assign stop_ok = rx_p1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= RX_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_fall) begin
                  bit_cnt  <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  // still high at mid start bit: glitch, not a frame
                  rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt  <= '0;
                  // even parity: data bits plus parity bit must XOR to 0
                  par_err  <= ^{rx_byte, rx_p1};
                  rx_state <= RX_STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (stop_ok) rx_done   <= 1'b1;
                  else         frame_err <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // byte shift register is pure data and carries no reset
   always_ff @(posedge clk) begin
      if (rx_state == RX_DATA && bit_cnt == BIT_LAST)
         rx_byte <= {rx_p1, rx_byte[7:1]};
   end

   // ---- command decoder: opcode latch, timeout, config registers ----
   dec_state_t       dec_state;
   logic [7:0]       op_reg;
   logic [TMO_W-1:0] tmo_cnt;
   logic             rx_idle;

   // timeout only runs while no frame is in progress
   assign rx_idle = (rx_state == RX_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_state  <= DEC_WAIT_OP;
         op_reg     <= '0;
         tmo_cnt    <= '0;
         blink_mask <= 8'h55;
         rate_sel   <= 2'd2;
         blink_en   <= 1'b1;
         cfg_strobe <= 1'b0;
      end else begin
         cfg_strobe <= 1'b0;
         case (dec_state)
            DEC_WAIT_OP: begin
               if (rx_done && is_opcode(rx_byte)) begin
                  op_reg    <= rx_byte;
                  tmo_cnt   <= '0;
                  dec_state <= DEC_WAIT_DATA;
               end
            end
            DEC_WAIT_DATA: begin
               if (rx_done) begin
                  case (op_reg)
                     OP_MASK: blink_mask <= rx_byte;
                     OP_RATE: rate_sel   <= rx_byte[1:0];
                     default: blink_en   <= rx_byte[0];
                  endcase
                  cfg_strobe <= 1'b1;
                  dec_state  <= DEC_WAIT_OP;
               end else if (frame_err) begin
                  dec_state <= DEC_WAIT_OP;
               end else if (rx_idle) begin
                  if (tmo_cnt == TMO_LAST) dec_state <= DEC_WAIT_OP;
                  else                     tmo_cnt   <= tmo_cnt + 1'b1;
               end
            end
            default: dec_state <= DEC_WAIT_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_blink_cmd.sv
// Testbench for uart_blink_cmd. Bit timing is scaled down (BIT_CNT = 40) so
// the directed and randomized traffic fits in a short run; glitch length is
// scaled in the same proportion as a 50-cycle glitch at BIT_CNT = 217.
module tb_uart_blink_cmd;

   localparam int CLK_FREQ = 2_500_000;
   localparam int BAUD     = 62_500;
   localparam int TMO_BITS = 20;
   localparam int BITP     = CLK_FREQ / BAUD;
   localparam int HALF     = BITP / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] blink_mask;
   logic [1:0] rate_sel;
   logic       blink_en;
   logic       cfg_strobe;
   logic       frame_err;

   always #5 clk = ~clk;

   uart_blink_cmd #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD        (BAUD),
      .TIMEOUT_BITS(TMO_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .blink_mask(blink_mask),
      .rate_sel  (rate_sel),
      .blink_en  (blink_en),
      .cfg_strobe(cfg_strobe),
      .frame_err (frame_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // observed pulse counts, sampled on the falling edge
   int n_strobe = 0;
   int n_ferr   = 0;
   int n_both   = 0;
   always @(negedge clk) begin
      if (cfg_strobe) n_strobe++;
      if (frame_err) n_ferr++;
      if (cfg_strobe && frame_err) n_both++;
   end

   // reference model: command semantics only
   logic [7:0] m_mask = 8'h55;
   logic [1:0] m_rate = 2'd2;
   logic       m_en   = 1'b1;
   logic [7:0] m_op   = 8'h00;
   bit         m_have = 1'b0;
   int         e_strobe = 0;
   int         e_ferr   = 0;

   task automatic model_reset();
      m_mask = 8'h55; m_rate = 2'd2; m_en = 1'b1; m_have = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good, input int idle_bits);
      if (m_have && idle_bits >= TMO_BITS) m_have = 1'b0;
      if (!good) begin
         e_ferr++;
         m_have = 1'b0;
      end else if (m_have) begin
         if (m_op == 8'h4D)      m_mask = b;
         else if (m_op == 8'h52) m_rate = b[1:0];
         else                    m_en   = b[0];
         e_strobe++;
         m_have = 1'b0;
      end else if (b == 8'h4D || b == 8'h52 || b == 8'h45) begin
         m_op   = b;
         m_have = 1'b1;
      end
   endtask

   // Sends one frame after idle_bits idle periods. lat = cycles from stop-bit
   // start to the first cfg_strobe inside the stop bit (-1 if none).
   task automatic send(input logic [7:0] b, input bit bad_stop, input int idle_bits,
                       output int lat, output logic [7:0] mask_at);
      lat = -1;
      mask_at = 8'h00;
      repeat (idle_bits * BITP) @(negedge clk);
      model_byte(b, !bad_stop, idle_bits);
      rx = 1'b0;
      repeat (BITP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BITP) @(negedge clk);
      end
      rx = !bad_stop;
      for (int c = 0; c < BITP; c++) begin
         @(negedge clk);
         if (cfg_strobe && lat < 0) begin
            lat = c;
            mask_at = blink_mask;
         end
      end
      rx = 1'b1;
      if (bad_stop) repeat (BITP) @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      @(negedge clk);
      check({tag, "_mask"},   blink_mask, m_mask);
      check({tag, "_rate"},   rate_sel,   m_rate);
      check({tag, "_en"},     blink_en,   m_en);
      check({tag, "_strobes"}, n_strobe,  e_strobe);
      check({tag, "_ferrs"},   n_ferr,    e_ferr);
   endtask

   initial begin
      int         lat;
      logic [7:0] mk;
      logic [7:0] op_b;
      logic [7:0] ops [3];
      ops[0] = 8'h4D; ops[1] = 8'h52; ops[2] = 8'h45;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_mask", blink_mask, 8'h55);
      check("rst_rate", rate_sel, 2'd2);
      check("rst_en", blink_en, 1'b1);
      check("rst_strobe", cfg_strobe, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (10 * BITP) @(negedge clk);
      check_all("idle");

      // mask write, strobe timing
      send(8'h4D, 1'b0, 0, lat, mk);
      send(8'hF0, 1'b0, 1, lat, mk);
      check("mask_lat_window", (lat >= HALF + 2 && lat <= HALF + 5), 1);
      check("mask_at_strobe", mk, 8'hF0);
      check_all("mask_f0");

      // back-to-back rate and enable
      send(8'h52, 1'b0, 0, lat, mk);
      send(8'h07, 1'b0, 0, lat, mk);
      send(8'h45, 1'b0, 0, lat, mk);
      send(8'h00, 1'b0, 0, lat, mk);
      check_all("rate_en");

      // reset mid-stream: opcode latched, data byte partly received
      send(8'h4D, 1'b0, 1, lat, mk);
      rx = 1'b0;
      repeat (BITP) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         repeat (BITP) @(negedge clk);
      end
      rst_n = 1'b0;
      rx = 1'b1;
      #1;
      model_reset();
      check("midrst_mask", blink_mask, 8'h55);
      check("midrst_rate", rate_sel, 2'd2);
      check("midrst_en", blink_en, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30 * BITP) @(negedge clk);
      check_all("after_rst");
      send(8'h0F, 1'b0, 0, lat, mk);
      check_all("op_dropped_by_rst");

      // framing error then good command
      send(8'h4D, 1'b1, 1, lat, mk);
      send(8'h4D, 1'b0, 0, lat, mk);
      send(8'h0F, 1'b0, 0, lat, mk);
      check_all("ferr");

      // timeout
      send(8'h4D, 1'b0, 1, lat, mk);
      send(8'h33, 1'b0, 25, lat, mk);
      check_all("timeout");
      send(8'h4D, 1'b0, 1, lat, mk);
      send(8'h33, 1'b0, 0, lat, mk);
      check_all("after_timeout");

      // short low glitch: false start
      repeat (BITP) @(negedge clk);
      rx = 1'b0;
      repeat (9) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BITP) @(negedge clk);
      check_all("glitch");
      send(8'h00, 1'b0, 0, lat, mk);
      send(8'h4D, 1'b0, 0, lat, mk);
      send(8'hAA, 1'b0, 0, lat, mk);
      check_all("after_glitch");

      // randomized command pairs
      for (int k = 0; k < 30; k++) begin
         int sel;
         sel  = $urandom_range(0, 3);
         op_b = (sel == 3) ? 8'($urandom) : ops[sel];
         send(op_b, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), lat, mk);
         send(8'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0) ? $urandom_range(25, 28) : $urandom_range(0, 2),
              lat, mk);
         check_all($sformatf("rnd%0d", k));
      end

      check("strobe_ferr_overlap", n_both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
